task4_div: RTL and testbench
============================

TASK4_DIV -- requirements
Module: task4_div

Interface
REQ-001 Parameter: size, default 8, operand width; dividend is 2*size bits.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  dividend/divisor presented.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  2*size  numerator (MAC result form A*B+C).
REQ-007 divisor  input  size  denominator (B).
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  size  low size bits of dividend/divisor (A).
REQ-011 remainder  output  size  dividend mod divisor (C).
REQ-012 div_zero  output  1  divisor was zero, qualified by out_valid.
REQ-013 overflow  output  1  true quotient >= 2^size, qualified by out_valid.

Function
REQ-014 FSM states IDLE, CALC, DONE; IDLE after reset.
REQ-015 in_ready SHALL be 1 only in IDLE; accept when in_valid & in_ready on a rising edge; dividend/divisor captured into internal registers.
REQ-016 On accept with divisor != 0: go to CALC, run restoring division, one quotient bit per cycle, MSB first, over 2*size iterations.
REQ-017 Partial remainder register size+1 bits; subtract when partial >= divisor, set quotient bit 1, else 0; no overflow of internal arithmetic.
REQ-018 After iteration 2*size: go to DONE; out_valid asserted exactly 2*size+1 cycles after the accept edge.
REQ-019 On accept with divisor == 0: go to DONE next cycle; quotient = all ones, remainder = dividend[size-1:0], div_zero = 1, overflow = 0.
REQ-020 quotient, remainder, div_zero, overflow SHALL be registered and stable while out_valid = 1.
REQ-021 In DONE, out_valid held until out_ready = 1; on that edge return to IDLE, out_valid = 0.
REQ-022 in_valid during CALC or DONE ignored; no queuing; in_ready = 0.
REQ-023 Outputs change only in DONE entry; inputs changing during CALC do not affect result.
REQ-024 Dividend 0 with nonzero divisor: quotient 0, remainder 0, full latency.

Reset
REQ-025 reset_n = 0 asynchronously forces IDLE, in_ready = 1 after release, out_valid = 0, quotient = 0, remainder = 0, div_zero = 0, overflow = 0, iteration counter = 0.
REQ-026 Reset asserted mid-CALC or in DONE aborts the operation; no result is ever presented for it.

Configuration
REQ-027 Macro TASK4_DIV_OVERFLOW_EN: when defined, overflow = 1 when internal quotient bits [2*size-1:size] nonzero; quotient still outputs low size bits.
REQ-028 Without TASK4_DIV_OVERFLOW_EN: overflow tied to 0, no overflow logic synthesised; all other behaviour identical.

Verification (size = 8)
REQ-029 Round trip: dividend 0x007D, divisor 0x0A -> quotient 0x0C, remainder 0x05, div_zero 0, out_valid at accept+17 cycles.
REQ-030 dividend 0x1234, divisor 0x56 -> quotient 0x36, remainder 0x10, overflow 0.
REQ-031 dividend 0x1234, divisor 0x00 -> out_valid at accept+1, quotient 0xFF, remainder 0x34, div_zero 1.
REQ-032 dividend 0xFFFF, divisor 0x01 -> quotient 0xFF, remainder 0x00, overflow 1 with macro, 0 without.
REQ-033 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready 0, second in_valid ignored; accepted after out_ready pulse.
REQ-034 reset_n pulsed low at accept+6 -> out_valid never asserts, all outputs 0, next operation 0x007D/0x0A gives 0x0C/0x05.

Source files
------------

// File: rtl/task4_div.sv
// task4_div: multi-cycle restoring divider, 2*size-bit dividend by size-bit divisor, one quotient bit per cycle.
// Optional TASK4_DIV_OVERFLOW_EN flags quotients that do not fit in size bits.
module task4_div #(
  parameter int size = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*size-1:0] dividend,
  input  logic [size-1:0]   divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [size-1:0]   quotient,
  output logic [size-1:0]   remainder,
  output logic              div_zero,
  output logic              overflow
);
  localparam int CW = $clog2(2*size+1);
  localparam logic [CW-1:0] LAST = CW'(2*size);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [2*size-1:0] dvd;
  logic [size-1:0] dvs, rem, rem_nxt;
  logic [size:0] sh;
  logic [CW-1:0] cnt;
  logic accept, zero, ge, finish;
  // dvd shifts dividend bits out of its top and quotient bits into its bottom
  always_comb begin
    accept = in_valid && state == IDLE;
    zero = dvs == '0;
    finish = state == CALC && (zero || cnt == LAST);
    sh = {rem, dvd[2*size-1]};
    ge = sh >= {1'b0, dvs};
    rem_nxt = ge ? size'(sh - {1'b0, dvs}) : sh[size-1:0];
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nxt = state == IDLE ? (in_valid ? CALC : IDLE) :
                state == CALC ? (finish ? DONE : CALC) :
                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dvd <= dividend;
        dvs <= divisor;
        rem <= '0;
        cnt <= '0;
      end else if (state == CALC && cnt != LAST) begin
        dvd <= {dvd[2*size-2:0], ge};
        rem <= rem_nxt;
        cnt <= cnt + 1'b1;
      end
      // a zero divisor leaves CALC after one cycle with the fixed result
      if (finish) begin
        quotient <= zero ? '1 : dvd[size-1:0];
        remainder <= zero ? dvd[size-1:0] : rem;
        div_zero <= zero;
      end
    end
`ifdef TASK4_DIV_OVERFLOW_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) overflow <= 1'b0;
    else if (finish) overflow <= !zero && |dvd[2*size-1:size];
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_task4_div.sv
// tb_task4_div: directed scoreboard bench for task4_div (size 8), latency, backpressure and reset abort.
module tb_task4_div;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div_zero, overflow;
  logic [15:0] dividend = '0;
  logic [7:0] divisor = '0, quotient, remainder;
  int tests = 0, fails = 0;
  typedef struct packed {logic [7:0] q; logic [7:0] r; logic dz; logic ov;} exp_t;
  exp_t sb[$];
`ifdef TASK4_DIV_OVERFLOW_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  task4_div #(.size(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic edz, input logic eov,
                        input int lat, input int hold);
    exp_t e;
    int cycles;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back('{q: eq, r: er, dz: edz, ov: eov});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (!out_valid) begin
        dividend = 16'($urandom);
        divisor = 8'($urandom);
      end
    end while (!out_valid && cycles < 100);
    chk("latency", 32'(cycles), 32'(lat));
    e = sb.pop_front();
    chk("quotient", 32'(quotient), 32'(e.q));
    chk("remainder", 32'(remainder), 32'(e.r));
    chk("div_zero", 32'(div_zero), 32'(e.dz));
    chk("overflow", 32'(overflow), 32'(e.ov));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 16'h0001;
      divisor = 8'h01;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_quotient", 32'(quotient), 32'(e.q));
      chk("hold_remainder", 32'(remainder), 32'(e.r));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 0);
    chk("release_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_div_zero", 32'(div_zero), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    run_op(16'h007D, 8'h0A, 8'h0C, 8'h05, 1'b0, 1'b0, 17, 0);
    run_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 17, 5);
    run_op(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1, 2);
    run_op(16'hFFFF, 8'h01, 8'hFF, 8'h00, 1'b0, OV, 17, 0);
    run_op(16'h0000, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 17, 0);
    run_op(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 17, 0);
    run_op(16'h0100, 8'h01, 8'h00, 8'h00, 1'b0, OV, 17, 1);
    run_op(16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 17, 0);
    // abort an operation mid-CALC: nothing may ever come out for it
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'h007D;
    divisor = 8'h0A;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    chk("abort_div_zero", 32'(div_zero), 0);
    chk("abort_overflow", 32'(overflow), 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    run_op(16'h007D, 8'h0A, 8'h0C, 8'h05, 1'b0, 1'b0, 17, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
